operand_fetch_unit: RTL and testbench
=====================================

Name: operand_fetch_unit

Overview:
- Parametrised successor to the instruction fetcher.
- Fetches one opcode plus operand bytes from memory, resolves the effective address for all eight group-01 addressing modes, and hands a decoded instruction to the execute stage over a valid/ack handshake.
- Owns the program counter and tolerates memory wait states.
- Sits between the memory arbiter and the execute/ALU control block.

Parameters:
REG_WIDTH, 8, data/register width in bits
ADDR_WIDTH, 16, address bus width in bits
RESET_VECTOR, 16'h0200, PC value loaded on reset
ZP_BITS, 8, width of zero-page address space; ZP results wrap modulo 2^ZP_BITS

Ports:
clk  in  1  system clock; all state changes on rising edge
reset_n  in  1  reset, synchronous, active-low
start  in  1  request fetch of next instruction at current PC
pc_load  in  1  load PC from pc_load_val
pc_load_val  in  ADDR_WIDTH  branch/jump target
mem_rd  out  1  memory read request
mem_addr  out  ADDR_WIDTH  read address
mem_data  in  REG_WIDTH  read data, valid when mem_ready=1
mem_ready  in  1  read completes this cycle
x_in  in  REG_WIDTH  X index register
y_in  in  REG_WIDTH  Y index register
opcode  out  REG_WIDTH  fetched opcode
eff_addr  out  ADDR_WIDTH  resolved effective address
imm  out  REG_WIDTH  immediate operand
mode  out  3  addressing mode, opcode[4:2]
op_valid  out  1  instruction ready; held until op_ack
op_ack  in  1  execute stage consumed instruction
page_cross  out  1  index add crossed a 256-byte page
busy  out  1  high in any state other than IDLE
pc  out  ADDR_WIDTH  current program counter

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE, pc=RESET_VECTOR; mem_rd, op_valid, page_cross, busy=0; opcode, eff_addr, imm, mode=0. Reset mid-fetch aborts the fetch; no partial result is presented.
- States: IDLE, OPC, OP_LO, OP_HI, PTR_LO, PTR_HI, IDX, DONE.
- Reads: every read state drives mem_rd=1 and holds mem_addr. It advances only on an edge where mem_ready=1, capturing mem_data on that edge. With mem_ready=0 it stalls with outputs stable.
- PC increment: +1 per completed OPC/OP_LO/OP_HI read, modulo 2^ADDR_WIDTH. PTR reads do not change PC.
- IDLE: start=1 -> OPC.
- pc_load: pc_load in IDLE loads PC. If pc_load and start arrive in the same cycle, PC loads first and the fetch uses pc_load_val. pc_load outside IDLE/DONE is ignored.
- OPC: latch opcode and mode.
  - opcode[1:0]!=2'b01: implied; go to DONE with eff_addr=0, imm=0.
  - Otherwise -> OP_LO.
- OP_LO routing by mode:
  - 010 imm: imm=data -> DONE.
  - 001 zp: eff_addr=data -> DONE.
  - 101 zp,X: eff_addr=(data+x_in) mod 2^ZP_BITS -> IDX (one internal cycle, mem_rd=0) -> DONE.
  - 000 (zp,X): ptr=(data+x_in) mod 2^ZP_BITS -> PTR_LO.
  - 100 (zp),Y: ptr=data -> PTR_LO.
  - 011/110/111 abs variants -> OP_HI.
- Little-endian throughout: low byte first.
- OP_HI: base={data,lo}. abs: eff_addr=base. abs,Y/abs,X: eff_addr=base+y_in/x_in, page_cross=(carry out of bit 7). Then -> DONE.
- PTR_LO reads ptr. PTR_HI reads (ptr+1) mod 2^ZP_BITS. Then eff_addr={hi,lo}; for (zp),Y add y_in with page_cross as above. -> DONE.
- DONE: op_valid=1, outputs stable.
  - op_ack=1 -> IDLE.
  - op_ack and start in the same cycle -> OPC directly, with no idle bubble.
  - start without op_ack is ignored.
- Zero-wait latency, measured from the edge sampling start to the first cycle with op_valid=1:
  - implied: 2
  - imm, zp: 3
  - zp,X: 4
  - abs, abs,X, abs,Y: 4
  - (zp,X), (zp),Y: 6

Optional Feature:
- Macro PAGE_CROSS_PENALTY_EN.
- Defined: when page_cross=1 in abs,X, abs,Y or (zp),Y, insert one extra IDX cycle (mem_rd=0) before DONE. This matches 6502 timing; latency is +1 on page cross only.
- Undefined: no penalty cycle. page_cross is still reported.

Test Plan:
- Reset, mem_ready=1, mem[0200]=A9, mem[0201]=42, pulse start -> op_valid 3 cycles later, opcode=A9, mode=010, imm=42, pc=0202.
- pc_load_val=0300 and start in the same IDLE cycle, mem[0300..0302]=BD,FF,12, x_in=01 -> eff_addr=1300, page_cross=1, pc=0303. Latency is 4 with PAGE_CROSS_PENALTY_EN undefined, 5 with it defined.
- mem=A1,FF (zp,X), x_in=01, mem[0000]=34, mem[0001]=12 -> pointer wraps to 00, eff_addr=1234. Also zp,X with 80+90 -> eff_addr=0010.
- (zp),Y: mem=B1,FF, mem[00FF]=00, mem[0000]=20, y_in=05 -> eff_addr=2005, page_cross=0, PTR_HI read at 0000.
- abs with mem_ready held low 3 cycles on the OP_HI read -> mem_addr stable during the stall, latency 4+3=7, result unchanged. Assert reset_n=0 mid-stall -> IDLE, pc=0200, op_valid never asserted.
- Two instructions back-to-back, op_ack and start in the same DONE cycle -> second OPC read in the next cycle. start without op_ack in DONE -> ignored, op_valid held.

Source files
------------

// File: rtl/operand_fetch_unit_if.sv
// Signal bundle between the operand fetch unit, the memory arbiter and the execute stage.
// The slave modport is the fetch unit; the master modport is the surrounding controller side.
interface operand_fetch_unit_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_val;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_data;
  logic                  mem_ready;
  logic [REG_WIDTH-1:0]  x_in;
  logic [REG_WIDTH-1:0]  y_in;
  logic [REG_WIDTH-1:0]  opcode;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [REG_WIDTH-1:0]  imm;
  logic [2:0]            mode;
  logic                  op_valid;
  logic                  op_ack;
  logic                  page_cross;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] pc;

  modport master (
    output start, pc_load, pc_load_val, mem_data, mem_ready, x_in, y_in, op_ack,
    input  mem_rd, mem_addr, opcode, eff_addr, imm, mode, op_valid, page_cross, busy, pc
  );

  modport slave (
    input  start, pc_load, pc_load_val, mem_data, mem_ready, x_in, y_in, op_ack,
    output mem_rd, mem_addr, opcode, eff_addr, imm, mode, op_valid, page_cross, busy, pc
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: reads opcode + operands, resolves group-01 effective addresses, presents the
// decoded instruction over op_valid/op_ack. Define PAGE_CROSS_PENALTY_EN for 6502 page-cross timing.
module operand_fetch_unit #(
  parameter int                    REG_WIDTH    = 8,
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0200,
  parameter int                    ZP_BITS      = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  operand_fetch_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPC    = 3'd1;
  localparam logic [2:0] S_OP_LO  = 3'd2;
  localparam logic [2:0] S_OP_HI  = 3'd3;
  localparam logic [2:0] S_PTR_LO = 3'd4;
  localparam logic [2:0] S_PTR_HI = 3'd5;
  localparam logic [2:0] S_IDX    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [2:0] M_IZX = 3'b000;
  localparam logic [2:0] M_ZP  = 3'b001;
  localparam logic [2:0] M_IMM = 3'b010;
  localparam logic [2:0] M_ABS = 3'b011;
  localparam logic [2:0] M_IZY = 3'b100;
  localparam logic [2:0] M_ZPX = 3'b101;
  localparam logic [2:0] M_ABY = 3'b110;
  localparam logic [2:0] M_ABX = 3'b111;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] eff_q;
  logic [REG_WIDTH-1:0]  lo_q;
  logic [REG_WIDTH-1:0]  opcode_q;
  logic [REG_WIDTH-1:0]  imm_q;
  logic [ZP_BITS-1:0]    ptr_q;
  logic [2:0]            mode_q;
  logic                  page_cross_q;
  logic                  penalty_q;

  logic                  read_state;
  logic [REG_WIDTH-1:0]  zp_sum;
  logic [ZP_BITS-1:0]    zp_idx;
  logic [ZP_BITS-1:0]    ptr_inc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] idx_sum;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  idx_val;
  logic                  crossed;
  logic                  penalty;

  assign read_state = (state == S_OPC) || (state == S_OP_LO) || (state == S_OP_HI) ||
                      (state == S_PTR_LO) || (state == S_PTR_HI);
  assign zp_sum  = bus.mem_data + bus.x_in;
  assign zp_idx  = zp_sum[ZP_BITS-1:0];
  assign ptr_inc = ptr_q + ZP_BITS'(1);
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);

  // The high byte arrives on the bus while lo_q holds either the operand or the pointer low byte.
  assign base    = ADDR_WIDTH'({bus.mem_data, lo_q});
  assign idx_sum = base + ADDR_WIDTH'(idx_val);
  assign crossed = idx_sum[ADDR_WIDTH-1:8] != base[ADDR_WIDTH-1:8];

`ifdef PAGE_CROSS_PENALTY_EN
  assign penalty = crossed;
`else
  assign penalty = 1'b0;
`endif

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    idx_val = '0;
    case (mode_q)
      M_ABX:        idx_val = bus.x_in;
      M_ABY, M_IZY: idx_val = bus.y_in;
      default:      ;
    endcase
  end

  always_comb begin
    addr = pc_q;
    case (state)
      S_PTR_LO: addr = ADDR_WIDTH'(ptr_q);
      S_PTR_HI: addr = ADDR_WIDTH'(ptr_inc);
      default:  ;
    endcase
  end

  assign bus.mem_rd     = read_state;
  assign bus.mem_addr   = addr;
  assign bus.opcode     = opcode_q;
  assign bus.eff_addr   = eff_q;
  assign bus.imm        = imm_q;
  assign bus.mode       = mode_q;
  assign bus.op_valid   = (state == S_DONE);
  assign bus.page_cross = page_cross_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.pc         = pc_q;

  // Indirect modes always spend one IDX cycle resolving the pointer result before DONE;
  // penalty_q adds a second IDX cycle when a page-cross penalty applies there.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state        <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      eff_q        <= '0;
      lo_q         <= '0;
      opcode_q     <= '0;
      imm_q        <= '0;
      ptr_q        <= '0;
      mode_q       <= '0;
      page_cross_q <= 1'b0;
      penalty_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.pc_load) pc_q <= bus.pc_load_val;
          if (bus.start)   state <= S_OPC;
        end
        S_OPC: if (bus.mem_ready) begin
          opcode_q     <= bus.mem_data;
          mode_q       <= bus.mem_data[4:2];
          eff_q        <= '0;
          imm_q        <= '0;
          page_cross_q <= 1'b0;
          penalty_q    <= 1'b0;
          pc_q         <= pc_inc;
          state        <= (bus.mem_data[1:0] == 2'b01) ? S_OP_LO : S_DONE;
        end
        S_OP_LO: if (bus.mem_ready) begin
          lo_q <= bus.mem_data;
          pc_q <= pc_inc;
          case (mode_q)
            M_IMM: begin imm_q <= bus.mem_data;              state <= S_DONE;   end
            M_ZP:  begin eff_q <= ADDR_WIDTH'(bus.mem_data); state <= S_DONE;   end
            M_ZPX: begin eff_q <= ADDR_WIDTH'(zp_idx);       state <= S_IDX;    end
            M_IZX: begin ptr_q <= zp_idx;                    state <= S_PTR_LO; end
            M_IZY: begin ptr_q <= bus.mem_data[ZP_BITS-1:0]; state <= S_PTR_LO; end
            default:     state <= S_OP_HI;
          endcase
        end
        S_OP_HI: if (bus.mem_ready) begin
          eff_q        <= idx_sum;
          page_cross_q <= crossed;
          pc_q         <= pc_inc;
          state        <= penalty ? S_IDX : S_DONE;
        end
        S_PTR_LO: if (bus.mem_ready) begin
          lo_q  <= bus.mem_data;
          state <= S_PTR_HI;
        end
        S_PTR_HI: if (bus.mem_ready) begin
          eff_q        <= idx_sum;
          page_cross_q <= crossed;
          penalty_q    <= penalty;
          state        <= S_IDX;
        end
        S_IDX: begin
          if (penalty_q) penalty_q <= 1'b0;
          else           state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.pc_load) pc_q <= bus.pc_load_val;
          if (bus.op_ack)  state <= bus.start ? S_OPC : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: directed cases plus randomized instructions
// compared against an instruction-level model of addressing-mode semantics and zero-wait latency.
module tb_operand_fetch_unit;

`ifdef PAGE_CROSS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  typedef struct packed {
    logic [7:0]  opcode;
    logic [2:0]  mode;
    logic [15:0] eff;
    logic [7:0]  imm;
    logic        pcross;
    logic [15:0] next_pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  operand_fetch_unit_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  operand_fetch_unit #(
    .REG_WIDTH(8), .ADDR_WIDTH(16), .RESET_VECTOR(16'h0200), .ZP_BITS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_data = mem[bus.mem_addr];

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_cur;
  bit          exp_armed = 1'b0;
  bit          junk_load = 1'b0;
  logic [15:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Instruction-level reference: what a group-01 instruction at pc0 must resolve to.
  function automatic void model(input logic [15:0] pc0, input logic [7:0] x, input logic [7:0] y,
                                output exp_t e, output int lat);
    logic [7:0]  op, b1, p;
    logic [15:0] base, idx;
    op = mem[pc0];
    b1 = mem[16'(pc0 + 1)];
    e = '0;
    e.opcode  = op;
    e.mode    = op[4:2];
    e.next_pc = pc0 + 16'd1;
    lat = 2;
    if (op[1:0] != 2'b01) return;
    e.next_pc = pc0 + 16'd2;
    lat = 3;
    case (op[4:2])
      3'd2: e.imm = b1;
      3'd1: e.eff = {8'h00, b1};
      3'd5: begin e.eff = {8'h00, 8'(b1 + x)}; lat = 4; end
      3'd0, 3'd4: begin
        p      = (op[4:2] == 3'd0) ? 8'(b1 + x) : b1;
        base   = {mem[{8'h00, 8'(p + 1)}], mem[{8'h00, p}]};
        idx    = (op[4:2] == 3'd4) ? {8'h00, y} : 16'h0000;
        e.eff  = base + idx;
        e.pcross = (base[15:8] != e.eff[15:8]);
        lat    = 6 + (e.pcross ? PEN : 0);
      end
      default: begin
        base   = {mem[16'(pc0 + 2)], b1};
        idx    = (op[4:2] == 3'd3) ? 16'h0000 : (op[4:2] == 3'd6) ? {8'h00, y} : {8'h00, x};
        e.eff  = base + idx;
        e.pcross = (base[15:8] != e.eff[15:8]);
        e.next_pc = pc0 + 16'd3;
        lat    = 4 + (e.pcross ? PEN : 0);
      end
    endcase
  endfunction

  // Whenever an instruction is presented, it must match the model's expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.op_valid === 1'b1) begin
      if (!exp_armed) check("spurious_op_valid", bus.op_valid, 0);
      else begin
        check("opcode",     bus.opcode,     exp_cur.opcode);
        check("mode",       bus.mode,       exp_cur.mode);
        check("eff_addr",   bus.eff_addr,   exp_cur.eff);
        check("imm",        bus.imm,        exp_cur.imm);
        check("page_cross", bus.page_cross, exp_cur.pcross);
        check("pc",         bus.pc,         exp_cur.next_pc);
        check("busy_done",  bus.busy,       1);
        check("no_rd_done", bus.mem_rd,     0);
      end
    end
  end

  // Called on a negedge; issues start (optionally with pc_load / op_ack) and waits for op_valid.
  task automatic run_instr(input bit do_load, input logic [15:0] ld_val, input bit chain,
                           input bit rand_wait, input int stall_at, input int stall_len,
                           output int lat);
    exp_t        e;
    int          want_lat, stalls;
    bit          prev_stall, done;
    logic [15:0] prev_addr, pc0;
    pc0 = do_load ? ld_val : model_pc;
    model(pc0, bus.x_in, bus.y_in, e, want_lat);
    bus.start = 1'b1; bus.pc_load = do_load; bus.pc_load_val = ld_val; bus.op_ack = chain;
    @(posedge clk);
    exp_cur = e; exp_armed = 1'b1;
    stalls = 0; prev_stall = 1'b0; prev_addr = '0; done = 1'b0; lat = 0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0; bus.pc_load = 1'b0; bus.op_ack = 1'b0;
        check("opc_read_issued", bus.mem_rd, 1);
        check("opc_read_addr", bus.mem_addr, pc0);
      end
      if (prev_stall) check("stall_addr_hold", bus.mem_addr, prev_addr);
      if (bus.op_valid) begin
        done = 1'b1; lat = c; bus.pc_load = 1'b0; bus.mem_ready = 1'b1;
      end else begin
        if (c >= stall_at && c < stall_at + stall_len) bus.mem_ready = 1'b0;
        else if (rand_wait) bus.mem_ready = ($urandom_range(0, 3) != 0);
        else bus.mem_ready = 1'b1;
        if (junk_load) begin bus.pc_load = 1'b1; bus.pc_load_val = 16'($urandom); end
        prev_stall = bus.mem_rd && !bus.mem_ready;
        if (prev_stall) stalls++;
        prev_addr = bus.mem_addr;
      end
    end
    if (!done) check("op_valid_timeout", bus.op_valid, 1);
    check("latency", lat, want_lat + stalls);
    model_pc = e.next_pc;
  endtask

  task automatic ack_instr();
    bus.op_ack = 1'b1;
    @(negedge clk);
    bus.op_ack = 1'b0; exp_armed = 1'b0;
    check("idle_after_ack", bus.busy, 0);
  endtask

  initial begin
    int          lat;
    bit          chain, ld, in_done;
    logic [15:0] pc0;
    logic [7:0]  opc;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.start = 1'b0; bus.pc_load = 1'b0; bus.pc_load_val = '0; bus.mem_ready = 1'b1;
    bus.x_in = '0; bus.y_in = '0; bus.op_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_pc", bus.pc, 16'h0200);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_page_cross", bus.page_cross, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_eff_addr", bus.eff_addr, 0);
    check("rst_imm", bus.imm, 0);
    check("rst_mode", bus.mode, 0);
    model_pc = 16'h0200;

    // LDA #42
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, lat);
    check("t1_latency", lat, 3);
    check("t1_opcode", bus.opcode, 8'hA9);
    check("t1_mode", bus.mode, 3'b010);
    check("t1_imm", bus.imm, 8'h42);
    check("t1_pc", bus.pc, 16'h0202);
    ack_instr();

    // abs,X with page cross, PC loaded in the same cycle as start
    mem[16'h0300] = 8'hBD; mem[16'h0301] = 8'hFF; mem[16'h0302] = 8'h12;
    bus.x_in = 8'h01;
    run_instr(1'b1, 16'h0300, 1'b0, 1'b0, 0, 0, lat);
    check("t2_latency", lat, 4 + PEN);
    check("t2_eff", bus.eff_addr, 16'h1300);
    check("t2_page_cross", bus.page_cross, 1);
    check("t2_pc", bus.pc, 16'h0303);
    ack_instr();

    // (zp,X) with pointer wrap to 00
    mem[16'h0303] = 8'hA1; mem[16'h0304] = 8'hFF; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, lat);
    check("t3_latency", lat, 6);
    check("t3_eff", bus.eff_addr, 16'h1234);
    ack_instr();

    // zp,X wrap: 80 + 90 -> 10
    mem[16'h0305] = 8'hB5; mem[16'h0306] = 8'h80; bus.x_in = 8'h90;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, lat);
    check("t3b_latency", lat, 4);
    check("t3b_eff", bus.eff_addr, 16'h0010);
    ack_instr();

    // (zp),Y with pointer high byte read from 0000
    mem[16'h0307] = 8'hB1; mem[16'h0308] = 8'hFF; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h20;
    bus.y_in = 8'h05;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, lat);
    check("t4_latency", lat, 6);
    check("t4_eff", bus.eff_addr, 16'h2005);
    check("t4_page_cross", bus.page_cross, 0);
    ack_instr();

    // abs with 3 wait states on the high-byte read; pc_load pulses mid-fetch must be ignored
    mem[16'h0309] = 8'hAD; mem[16'h030A] = 8'h34; mem[16'h030B] = 8'h12;
    junk_load = 1'b1;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 3, 3, lat);
    junk_load = 1'b0;
    check("t5_latency", lat, 7);
    check("t5_eff", bus.eff_addr, 16'h1234);
    check("t5_pc", bus.pc, 16'h030C);
    ack_instr();

    // reset while stalled on the high-byte read
    mem[16'h030C] = 8'hAD; mem[16'h030D] = 8'h00; mem[16'h030E] = 8'h30;
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk);
    check("t5r_stall_rd", bus.mem_rd, 1);
    check("t5r_stall_addr", bus.mem_addr, 16'h030E);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; bus.mem_ready = 1'b1;
    check("t5r_busy", bus.busy, 0);
    check("t5r_pc", bus.pc, 16'h0200);
    check("t5r_mem_rd", bus.mem_rd, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5r_no_valid", bus.op_valid, 0);
    end
    model_pc = 16'h0200;

    // implied, start without ack ignored, then back-to-back into LDA #77
    mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hA9; mem[16'h0202] = 8'h77;
    run_instr(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, lat);
    check("t6_latency", lat, 2);
    check("t6_opcode", bus.opcode, 8'hEA);
    check("t6_eff", bus.eff_addr, 0);
    check("t6_pc", bus.pc, 16'h0201);
    bus.start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_hold_valid", bus.op_valid, 1);
      check("t6_hold_no_rd", bus.mem_rd, 0);
    end
    bus.start = 1'b0;
    run_instr(1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, lat);
    check("t6b_latency", lat, 3);
    check("t6b_imm", bus.imm, 8'h77);
    in_done = 1'b1;

    // randomized instructions, wait states, loads and chaining
    for (int i = 0; i < 200; i++) begin
      chain = ($urandom_range(0, 1) == 1);
      if (!chain && in_done) ack_instr();
      ld  = ($urandom_range(0, 4) == 0);
      pc0 = ld ? 16'($urandom) : model_pc;
      opc = 8'($urandom);
      if ($urandom_range(0, 3) != 0) opc[1:0] = 2'b01;
      mem[pc0] = opc;
      bus.x_in = 8'($urandom); bus.y_in = 8'($urandom);
      junk_load = ($urandom_range(0, 3) == 0);
      run_instr(ld, pc0, chain && in_done, ($urandom_range(0, 1) == 1), 0, 0, lat);
      junk_load = 1'b0;
      in_done = 1'b1;
    end
    ack_instr();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
